// File: rtl/serial_fetch_arbiter.sv
// Serial memory port sequencer: counts serial bits per byte and
// arbitrates the port between instruction fetch and one data requester.
module serial_fetch_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int BYTE_BITS  = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclkPosEdge,
  input  logic                  runEn,
  input  logic                  haltReq,
  input  logic [ADDR_WIDTH-1:0] pcAddr,
  input  logic                  dataReq,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  output logic [ADDR_WIDTH-1:0] memAddrOut,
  output logic                  busy,
  output logic                  pcEn,
  output logic                  fetchDone,
  output logic                  dataGnt,
  output logic                  dataDone,
  output logic                  halted
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_bitCnt;
  logic                  r_lastWasData;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_pcEn;
  logic                  r_dataGnt;
  logic                  r_dataDone;

  logic                  w_xfer;
  logic                  w_end;
  logic                  w_enter;
  logic [1:0]            w_pick;
  logic [1:0]            w_pickD;
  logic [1:0]            w_next;

  assign w_xfer = (r_state == S_FETCH) || (r_state == S_DATA);
  assign w_end  = w_xfer && sclkPosEdge &&
                  (r_bitCnt == CNT_WIDTH'(BYTE_BITS - 1));

  // Arbitration from IDLE, alternating on the last transfer type
  always_comb begin
    w_pick = S_IDLE;
    if (haltReq)
      w_pick = S_HALT;
    else if (dataReq && runEn)
      w_pick = r_lastWasData ? S_FETCH : S_DATA;
    else if (dataReq)
      w_pick = S_DATA;
    else if (runEn)
      w_pick = S_FETCH;
  end

  // Same rules right after a data byte, where lastWasData becomes 1
  always_comb begin
    w_pickD = S_IDLE;
    if (haltReq)
      w_pickD = S_HALT;
    else if (runEn)
      w_pickD = S_FETCH;
    else if (dataReq)
      w_pickD = S_DATA;
  end

  // Next state; a finished fetch always spends one clk in IDLE
  // so the advanced PC is visible before the next fetch address
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_pick;
      S_FETCH: if (w_end) w_next = S_IDLE;
      S_DATA:  if (w_end) w_next = w_pickD;
      S_HALT:  if (!haltReq) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter = ((w_next == S_FETCH) || (w_next == S_DATA)) &&
                   ((r_state == S_IDLE) || w_end);

  // State, bit counter, address capture and registered strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_bitCnt      <= '0;
      r_lastWasData <= 1'b0;
      r_addr        <= '0;
      r_pcEn        <= 1'b0;
      r_dataGnt     <= 1'b0;
      r_dataDone    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pcEn     <= w_end && (r_state == S_FETCH);
      r_dataDone <= w_end && (r_state == S_DATA);
      r_dataGnt  <= w_enter && (w_next == S_DATA);
      if (w_end)
        r_lastWasData <= (r_state == S_DATA);
      if (w_enter) begin
        r_bitCnt <= '0;
        r_addr   <= (w_next == S_DATA) ? dataAddr : pcAddr;
      end else if (w_xfer && sclkPosEdge) begin
        r_bitCnt <= w_end ? '0 : r_bitCnt + 1'b1;
      end
    end
  end

  assign memAddrOut = r_addr;
  assign busy       = w_xfer;
  assign halted     = (r_state == S_HALT);
  assign pcEn       = r_pcEn;
  assign fetchDone  = r_pcEn;
  assign dataGnt    = r_dataGnt;
  assign dataDone   = r_dataDone;

endmodule

// File: tb/tb_serial_fetch_arbiter.sv
// Directed bench for serial_fetch_arbiter: a per-cycle vector table
// plus hand-written multi-cycle sequences.
module tb_serial_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclkPosEdge = 1'b0;
  logic        runEn = 1'b0;
  logic        haltReq = 1'b0;
  logic [15:0] pcAddr;
  logic        dataReq = 1'b0;
  logic [15:0] dataAddr = 16'h0;
  logic [15:0] memAddrOut;
  logic        busy, pcEn, fetchDone, dataGnt, dataDone, halted;

  int n_tests = 0;
  int n_fail  = 0;

  serial_fetch_arbiter dut (
    .clk(clk), .reset(reset), .sclkPosEdge(sclkPosEdge),
    .runEn(runEn), .haltReq(haltReq), .pcAddr(pcAddr),
    .dataReq(dataReq), .dataAddr(dataAddr),
    .memAddrOut(memAddrOut), .busy(busy), .pcEn(pcEn),
    .fetchDone(fetchDone), .dataGnt(dataGnt),
    .dataDone(dataDone), .halted(halted)
  );

  always #5 clk = ~clk;

  // Program counter model: advances within the pcEn cycle
  logic        pc_ld = 1'b0;
  logic [15:0] pc_ldval = 16'h0;
  logic [15:0] pc = 16'h0;
  always @(negedge clk) begin
    if (pc_ld) pc <= pc_ldval;
    else if (pcEn) pc <= pc + 16'd1;
  end
  assign pcAddr = pc;

  typedef struct {
    logic        sclk, run, halt, dreq;
    logic [15:0] addr;
    logic        busy, pcen, gnt, dd, hlt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic r, logic h, logic d,
                              logic [15:0] a, logic b, logic p,
                              logic g, logic dd, logic hl);
    vec_t v;
    v.sclk = s; v.run = r; v.halt = h; v.dreq = d; v.addr = a;
    v.busy = b; v.pcen = p; v.gnt = g; v.dd = dd; v.hlt = hl;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setpc(logic [15:0] v);
    pc_ldval = v;
    pc_ld = 1'b1;
    @(negedge clk);
    #1 pc_ld = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sclkPosEdge = 0; runEn = 0; haltReq = 0; dataReq = 0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  int npc, ngnt, ndd, novl, seq;
  logic [15:0] a_fetch1, a_fetch2;

  initial begin
    do_reset();
    chk("rst.addr", memAddrOut, 0);
    chk("rst.busy", busy, 0);
    chk("rst.halted", halted, 0);
    chk("rst.strobes", {pcEn, fetchDone, dataGnt, dataDone}, 0);

    // ---- vector table: data byte, back-to-back fetch, halt ----
    setpc(16'h0040);
    dataAddr = 16'h0100;
    tbl.push_back(mk(0,0,0,0, 16'h0000,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 16'h0100,1,0,1,0,0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1,0,0,0, 16'h0100,1,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 16'h0040,1,0,0,1,0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1,0,0,0, 16'h0040,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 16'h0040,0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 16'h0040,0,0,0,0,1));
    tbl.push_back(mk(0,1,1,0, 16'h0040,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 16'h0040,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 16'h0040,0,0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) begin
      sclkPosEdge = tbl[i].sclk; runEn = tbl[i].run;
      haltReq = tbl[i].halt; dataReq = tbl[i].dreq;
      tick();
      chk($sformatf("tbl%0d.addr", i), memAddrOut, tbl[i].addr);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d.pcEn", i), pcEn, tbl[i].pcen);
      chk($sformatf("tbl%0d.fdone", i), fetchDone, tbl[i].pcen);
      chk($sformatf("tbl%0d.gnt", i), dataGnt, tbl[i].gnt);
      chk($sformatf("tbl%0d.ddone", i), dataDone, tbl[i].dd);
      chk($sformatf("tbl%0d.halted", i), halted, tbl[i].hlt);
    end

    // ---- 1: fetch with a strobe every 4 clk ----
    do_reset();
    setpc(16'h0010);
    runEn = 1;
    tick();
    chk("t1.addr", memAddrOut, 16'h0010);
    chk("t1.busy", busy, 1);
    npc = 0;
    for (int s = 0; s < 8; s++) begin
      sclkPosEdge = 1;
      tick();
      sclkPosEdge = 0;
      if (pcEn) npc++;
      if (s == 7) chk("t1.pcEn_at8", pcEn, 1);
      for (int k = 0; k < 3; k++) begin
        tick();
        if (pcEn) npc++;
      end
    end
    chk("t1.pcEn_count", npc, 1);
    chk("t1.next_addr", memAddrOut, 16'h0011);
    chk("t1.next_busy", busy, 1);

    // ---- 2: alternation with both requesters active ----
    do_reset();
    setpc(16'h0200);
    dataAddr = 16'h1234;
    runEn = 1; dataReq = 1;
    ngnt = 0; ndd = 0; npc = 0; novl = 0; seq = 0;
    a_fetch1 = 0; a_fetch2 = 0;
    for (int t = 1; t <= 26; t++) begin
      tick();
      sclkPosEdge = 1;
      if (dataGnt) begin ngnt++; seq = seq * 4 + 1; end
      if (pcEn) begin npc++; seq = seq * 4 + 2; end
      if (dataDone) begin ndd++; seq = seq * 4 + 3; end
      if ((pcEn && dataDone) || (pcEn && dataGnt)) novl++;
      if (t == 1) chk("t2.daddr", memAddrOut, 16'h1234);
      if (t == 9) a_fetch1 = memAddrOut;
      if (t == 26) a_fetch2 = memAddrOut;
    end
    sclkPosEdge = 0; runEn = 0; dataReq = 0;
    chk("t2.gnt_count", ngnt, 2);
    chk("t2.ddone_count", ndd, 2);
    chk("t2.pcEn_count", npc, 1);
    chk("t2.overlap", novl, 0);
    // G,D,P,G,D encoded 1,3,2,1,3 in base 4
    chk("t2.order", seq, 487);
    chk("t2.fetch1_addr", a_fetch1, 16'h0200);
    chk("t2.fetch2_addr", a_fetch2, 16'h0201);

    // ---- 3: halt requested mid-fetch ----
    do_reset();
    setpc(16'h0100);
    runEn = 1;
    tick();
    chk("t3.addr", memAddrOut, 16'h0100);
    sclkPosEdge = 1;
    for (int s = 1; s <= 8; s++) begin
      if (s == 3) haltReq = 1;
      tick();
      if (s < 8) chk($sformatf("t3.busy_s%0d", s), busy, 1);
    end
    sclkPosEdge = 0;
    chk("t3.pcEn", pcEn, 1);
    chk("t3.halted_early", halted, 0);
    tick();
    chk("t3.halted", halted, 1);
    chk("t3.busy_halt", busy, 0);
    tick();
    chk("t3.halted_hold", halted, 1);
    haltReq = 0;
    tick();
    chk("t3.unhalted", halted, 0);
    chk("t3.idle_busy", busy, 0);
    tick();
    chk("t3.resume_busy", busy, 1);
    chk("t3.resume_addr", memAddrOut, 16'h0101);

    // ---- 4: reset in the middle of a data byte ----
    do_reset();
    dataAddr = 16'h2222;
    dataReq = 1;
    tick();
    chk("t4.gnt", dataGnt, 1);
    dataReq = 0;
    sclkPosEdge = 1;
    for (int s = 0; s < 5; s++) tick();
    sclkPosEdge = 0;
    #2 reset = 0;
    #1;
    chk("t4.addr_async", memAddrOut, 0);
    chk("t4.busy_async", busy, 0);
    tick();
    tick();
    reset = 1;
    sclkPosEdge = 1;
    ndd = 0;
    for (int s = 0; s < 12; s++) begin
      tick();
      if (dataDone || busy) ndd++;
    end
    sclkPosEdge = 0;
    chk("t4.no_ddone", ndd, 0);

    // ---- 5: data address changes after grant ----
    do_reset();
    dataAddr = 16'h1234;
    dataReq = 1;
    tick();
    chk("t5.gnt", dataGnt, 1);
    dataAddr = 16'hBEEF;
    dataReq = 0;
    sclkPosEdge = 1;
    novl = 0; ndd = 0;
    for (int s = 0; s < 8; s++) begin
      tick();
      if (memAddrOut !== 16'h1234) novl++;
      if (dataDone) ndd++;
    end
    sclkPosEdge = 0;
    chk("t5.addr_stable", novl, 0);
    chk("t5.ddone", ndd, 1);

    // ---- 6: idle with strobes, then a clean 8-strobe fetch ----
    do_reset();
    setpc(16'h0300);
    novl = 0;
    for (int c = 0; c < 100; c++) begin
      sclkPosEdge = c[0];
      tick();
      if (busy || pcEn || dataGnt || dataDone || halted) novl++;
    end
    sclkPosEdge = 0;
    chk("t6.idle_quiet", novl, 0);
    runEn = 1;
    tick();
    runEn = 0;
    sclkPosEdge = 1;
    npc = 0;
    for (int s = 0; s < 7; s++) begin
      tick();
      if (pcEn) npc++;
    end
    chk("t6.no_early_pcEn", npc, 0);
    tick();
    sclkPosEdge = 0;
    chk("t6.pcEn_at8", pcEn, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
